// File: rtl/vm80a_sysctl.sv
// vm80a system controller: status latch, bus strobes,
// INTA opcode injection and per-cycle-type wait states.
module vm80a_sysctl #(
  parameter logic [7:0] INTA_OPCODE = 8'hE7,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic       pin_clk,
  input  logic       pin_reset,
  input  logic       pin_f1,
  input  logic       pin_f2,
  input  logic       cpu_sync,
  input  logic       cpu_dbin,
  input  logic       cpu_wr_n,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic       cpu_doe,
  input  logic [7:0] sys_din,
  output logic       cpu_ready,
  output logic [7:0] status,
  output logic       memr_n,
  output logic       memw_n,
  output logic       ior_n,
  output logic       iow_n,
  output logic       inta_n,
  output logic       hlta
);

  localparam logic [3:0] W_MEM = 4'(MEM_WAIT);
  localparam logic [3:0] W_IO  = 4'(IO_WAIT);

  logic       r_sync_q;
  logic       r_f2_q;
  logic [7:0] r_status;
  logic [3:0] r_cnt;
  logic       r_ready;
  logic       r_memr_n;
  logic       r_memw_n;
  logic       r_ior_n;
  logic       r_iow_n;
  logic       r_inta_n;

  logic       w_cap;
  logic       w_f2_rise;
  logic [3:0] w_load;
  logic       w_rd;
  logic       w_wr;
  logic       w_memr;
  logic       w_memw;
  logic       w_ior;
  logic       w_iow;
  logic       w_inta;
  logic       w_unused;

  // f1 is not needed: all timing keys off f2 rises
  assign w_unused = pin_f1;

  assign w_cap     = cpu_sync & ~r_sync_q;
  assign w_f2_rise = pin_f2 & ~r_f2_q;

  // wait-state load value from the status byte being captured
  always_comb begin
    w_load = W_MEM;
    if (cpu_dout[3])
      w_load = 4'd0;
    else if (cpu_dout[0] | cpu_dout[4] | cpu_dout[6])
      w_load = W_IO;
  end

  // strobe decode; halt blocks all, INTA outranks IO outranks MEM
  always_comb begin
    w_rd   = cpu_dbin & ~r_status[3];
    w_wr   = ~cpu_wr_n & ~cpu_dbin & ~r_status[3];
    w_inta = w_rd & r_status[0];
    w_ior  = w_rd & r_status[6] & ~r_status[0];
    w_memr = w_rd & r_status[7] & ~r_status[6]
           & ~r_status[0];
    w_iow  = w_wr & r_status[4];
    w_memw = w_wr & ~r_status[4] & ~r_status[0];
  end

  // edge detectors and status capture
  always_ff @(posedge pin_clk) begin
    if (pin_reset) begin
      r_sync_q <= 1'b0;
      r_f2_q   <= 1'b0;
      r_status <= 8'h00;
    end else begin
      r_sync_q <= cpu_sync;
      r_f2_q   <= pin_f2;
      if (w_cap)
        r_status <= cpu_dout;
    end
  end

  // wait counter; a capture overrides a same-edge decrement
  always_ff @(posedge pin_clk) begin
    if (pin_reset) begin
      r_cnt   <= 4'd0;
      r_ready <= 1'b1;
    end else begin
      r_ready <= (r_cnt == 4'd0);
      if (w_cap)
        r_cnt <= w_load;
      else if (w_f2_rise && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // registered active-low strobes
  always_ff @(posedge pin_clk) begin
    if (pin_reset) begin
      r_memr_n <= 1'b1;
      r_memw_n <= 1'b1;
      r_ior_n  <= 1'b1;
      r_iow_n  <= 1'b1;
      r_inta_n <= 1'b1;
    end else begin
      r_memr_n <= ~w_memr;
      r_memw_n <= ~w_memw;
      r_ior_n  <= ~w_ior;
      r_iow_n  <= ~w_iow;
      r_inta_n <= ~w_inta;
    end
  end

  assign cpu_doe   = cpu_dbin;
  assign cpu_din   = r_status[0] ? INTA_OPCODE : sys_din;
  assign cpu_ready = r_ready;
  assign status    = r_status;
  assign hlta      = r_status[3];
  assign memr_n    = r_memr_n;
  assign memw_n    = r_memw_n;
  assign ior_n     = r_ior_n;
  assign iow_n     = r_iow_n;
  assign inta_n    = r_inta_n;

endmodule

// File: tb/tb_vm80a_sysctl.sv
// Bench for vm80a_sysctl: cycle model compare plus
// directed bus cycles with literal expectations.
module tb_vm80a_sysctl;

  logic       pin_clk = 1'b0;
  logic       pin_reset = 1'b1;
  logic       pin_f1 = 1'b0;
  logic       pin_f2 = 1'b0;
  logic       cpu_sync = 1'b0;
  logic       cpu_dbin = 1'b0;
  logic       cpu_wr_n = 1'b1;
  logic [7:0] cpu_dout = 8'h00;
  logic [7:0] sys_din = 8'h00;
  logic [7:0] cpu_din;
  logic       cpu_doe;
  logic       cpu_ready;
  logic [7:0] status;
  logic       memr_n, memw_n, ior_n, iow_n, inta_n;
  logic       hlta;

  vm80a_sysctl #(
    .INTA_OPCODE(8'hE7),
    .MEM_WAIT(0),
    .IO_WAIT(2)
  ) dut (
    .pin_clk(pin_clk),
    .pin_reset(pin_reset),
    .pin_f1(pin_f1),
    .pin_f2(pin_f2),
    .cpu_sync(cpu_sync),
    .cpu_dbin(cpu_dbin),
    .cpu_wr_n(cpu_wr_n),
    .cpu_dout(cpu_dout),
    .cpu_din(cpu_din),
    .cpu_doe(cpu_doe),
    .sys_din(sys_din),
    .cpu_ready(cpu_ready),
    .status(status),
    .memr_n(memr_n),
    .memw_n(memw_n),
    .ior_n(ior_n),
    .iow_n(iow_n),
    .inta_n(inta_n),
    .hlta(hlta)
  );

  int ph = 0;
  int n_checks = 0;
  int n_fail = 0;

  // clock and a 4-clock f1/f2 phase pattern
  initial begin
    forever begin
      #5 pin_clk = 1'b1;
      #5 pin_clk = 1'b0;
      ph = (ph + 1) % 4;
      pin_f1 = (ph == 0);
      pin_f2 = (ph == 1 || ph == 2);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // model state
  logic [7:0] m_status = 8'h00;
  logic       m_syncq = 1'b0;
  logic       m_f2q = 1'b0;
  int         m_cnt = 0;
  logic       m_ready = 1'b1;
  int         m_kind = 0;
  logic       rdy_prev = 1'b1;

  int n_memr = 0;
  int n_ior = 0;
  int n_wf2 = 0;

  function automatic logic [4:0] strobes(input int k);
    logic [4:0] v;
    v = 5'h1f;
    case (k)
      1: v[4] = 1'b0;
      2: v[3] = 1'b0;
      3: v[2] = 1'b0;
      4: v[1] = 1'b0;
      5: v[0] = 1'b0;
      default: v = 5'h1f;
    endcase
    return v;
  endfunction

  // model: kind 1 memr 2 memw 3 ior 4 iow 5 inta
  always @(posedge pin_clk) begin
    int k;
    logic [7:0] s;
    if (pin_f2 && !m_f2q && !rdy_prev)
      n_wf2++;
    if (pin_reset) begin
      m_status = 8'h00;
      m_syncq = 1'b0;
      m_f2q = 1'b0;
      m_cnt = 0;
      m_ready = 1'b1;
      m_kind = 0;
    end else begin
      s = m_status;
      k = 0;
      if (!s[3]) begin
        if (cpu_dbin) begin
          if (s[0]) k = 5;
          else if (s[6]) k = 3;
          else if (s[7]) k = 1;
        end else if (!cpu_wr_n) begin
          if (s[4]) k = 4;
          else if (!s[0]) k = 2;
        end
      end
      m_kind = k;
      m_ready = (m_cnt == 0);
      if (cpu_sync && !m_syncq) begin
        m_status = cpu_dout;
        if (cpu_dout[3]) m_cnt = 0;
        else if ((cpu_dout & 8'h51) != 0) m_cnt = 2;
        else m_cnt = 0;
      end else if (pin_f2 && !m_f2q && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end
      m_syncq = cpu_sync;
      m_f2q = pin_f2;
    end
    #1;
    chk("status", 32'(status), 32'(m_status));
    chk("hlta", 32'(hlta), 32'(m_status[3]));
    chk("ready", 32'(cpu_ready), 32'(m_ready));
    chk("strobes",
        32'({memr_n, memw_n, ior_n, iow_n, inta_n}),
        32'(strobes(m_kind)));
    chk("doe", 32'(cpu_doe), 32'(cpu_dbin));
    chk("din", 32'(cpu_din),
        32'(m_status[0] ? 8'hE7 : sys_din));
    rdy_prev = cpu_ready;
    if (!memr_n) n_memr++;
    if (!ior_n) n_ior++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge pin_clk);
      #1;
    end
  endtask

  // SYNC for 2 clocks, starting so capture lands on ph==3
  task automatic sync_at(input logic [7:0] st);
    int g;
    g = 0;
    while (ph != 3 && g < 8) begin
      tick(1);
      g++;
    end
    cpu_sync = 1'b1;
    cpu_dout = st;
    tick(2);
    cpu_sync = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_status", 32'(status), 32'h00);
    chk("rst_strb",
        32'({memr_n, memw_n, ior_n, iow_n, inta_n}),
        32'h1f);
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_doe", 32'(cpu_doe), 32'd0);
    pin_reset = 1'b0;
    tick(2);

    // memory read, no waits
    n_memr = 0;
    n_wf2 = 0;
    sync_at(8'hA2);
    chk("mr_status", 32'(status), 32'hA2);
    sys_din = 8'h3C;
    cpu_dbin = 1'b1;
    tick(1);
    chk("mr_din", 32'(cpu_din), 32'h3C);
    chk("mr_memr", 32'(memr_n), 32'd0);
    tick(2);
    cpu_dbin = 1'b0;
    tick(2);
    chk("mr_cnt", 32'(n_memr), 32'd3);
    chk("mr_waits", 32'(n_wf2), 32'd0);

    // IN with two waits
    n_memr = 0;
    n_ior = 0;
    n_wf2 = 0;
    sync_at(8'h42);
    cpu_dbin = 1'b1;
    tick(10);
    cpu_dbin = 1'b0;
    tick(2);
    chk("in_waits", 32'(n_wf2), 32'd2);
    chk("in_ready", 32'(cpu_ready), 32'd1);
    chk("in_ior", 32'(n_ior), 32'd10);
    chk("in_memr", 32'(n_memr), 32'd0);

    // OUT then memory write
    sync_at(8'h10);
    cpu_dout = 8'h99;
    cpu_wr_n = 1'b0;
    tick(1);
    chk("out_iow", 32'(iow_n), 32'd0);
    chk("out_memw", 32'(memw_n), 32'd1);
    cpu_wr_n = 1'b1;
    tick(8);
    sync_at(8'h00);
    cpu_wr_n = 1'b0;
    tick(1);
    chk("wr_memw", 32'(memw_n), 32'd0);
    chk("wr_iow", 32'(iow_n), 32'd1);
    cpu_wr_n = 1'b1;
    tick(3);

    // interrupt acknowledge
    sync_at(8'h23);
    sys_din = 8'h55;
    cpu_dbin = 1'b1;
    tick(1);
    chk("inta_n", 32'(inta_n), 32'd0);
    chk("inta_doe", 32'(cpu_doe), 32'd1);
    chk("inta_din", 32'(cpu_din), 32'hE7);
    chk("inta_memr", 32'(memr_n), 32'd1);
    tick(8);
    cpu_dbin = 1'b0;
    tick(2);

    // halt
    sync_at(8'h8A);
    cpu_dbin = 1'b1;
    tick(1);
    chk("hlt_hlta", 32'(hlta), 32'd1);
    tick(3);
    chk("hlt_strb",
        32'({memr_n, memw_n, ior_n, iow_n, inta_n}),
        32'h1f);
    chk("hlt_ready", 32'(cpu_ready), 32'd1);
    cpu_dbin = 1'b0;
    sync_at(8'hA2);
    chk("hlt_clr", 32'(hlta), 32'd0);
    tick(2);

    // reset in the middle of a waited IN
    sync_at(8'h42);
    cpu_dbin = 1'b1;
    tick(1);
    chk("mid_ior", 32'(ior_n), 32'd0);
    chk("mid_rdy", 32'(cpu_ready), 32'd0);
    pin_reset = 1'b1;
    tick(1);
    chk("rr_strb",
        32'({memr_n, memw_n, ior_n, iow_n, inta_n}),
        32'h1f);
    chk("rr_ready", 32'(cpu_ready), 32'd1);
    chk("rr_status", 32'(status), 32'h00);
    pin_reset = 1'b0;
    cpu_dbin = 1'b0;
    tick(2);
    sync_at(8'hA2);
    chk("rr_recap", 32'(status), 32'hA2);
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
